// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared defaults and next-PC source encoding for the PC unit
package pc_unit_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int INC_DEF = 4;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    typedef enum logic [2:0] {
        SRC_REDIRECT,
        SRC_HOLD,
        SRC_CALL,
        SRC_RET,
        SRC_SEQ
    } pc_src_e;
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control inputs and PC/RAS status outputs of the PC unit
interface pc_unit_if import pc_unit_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;
    logic stall;
    logic redirect;
    logic [WIDTH-1:0] redirect_target;
    logic call;
    logic [WIDTH-1:0] call_target;
    logic ret;
    logic [WIDTH-1:0] pc_result;
    logic [WIDTH-1:0] pc_plus;
    logic [CW-1:0] ras_count;
    logic ret_miss;
    logic align_fault;
    modport master (
        output stall, redirect, redirect_target, call, call_target, ret,
        input pc_result, pc_plus, ras_count, ret_miss, align_fault
    );
    modport slave (
        input stall, redirect, redirect_target, call, call_target, ret,
        output pc_result, pc_plus, ras_count, ret_miss, align_fault
    );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_ras: DEPTH must be a power of two and at least 2");
    end
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] tp_q;
    logic [PW-1:0] tp_m1;
    logic [CW-1:0] count_q;
    assign tp_m1 = tp_q - 1'b1;
    assign top_o = mem_q[tp_m1];
    assign count_o = count_q;
    // entry storage is not reset; entries beyond the count are never read out
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[tp_q] <= push_data_i;
    end
    // tp_q is the next free slot; wrapping lets a full push drop the oldest entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tp_q <= '0;
            count_q <= '0;
        end else if (push_i) begin
            tp_q <= tp_q + 1'b1;
            count_q <= (count_q == CW'(DEPTH)) ? count_q : count_q + 1'b1;
        end else if (pop_i) begin
            tp_q <= tp_m1;
            count_q <= count_q - 1'b1;
        end
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with redirect/stall/call/return priority, RAS and fault pulses
module pc_unit import pc_unit_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF),
    parameter int INC = INC_DEF,
    parameter int RAS_DEPTH = 4
) (
    input logic clk_i,
    input logic rst_i,
    pc_unit_if.slave bus
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;
    localparam logic [WIDTH-1:0] LO_MASK = WIDTH'(INC - 1);
    if (INC < 1 || (INC & (INC - 1)) != 0) begin : g_bad_inc
        $error("pc_unit: INC must be a power of two");
    end
    pc_src_e src;
    logic [WIDTH-1:0] pc_q, pc_d, pc_plus, raw, ras_top;
    logic [CW-1:0] ras_count;
    logic ras_hit, is_target;
    logic ret_miss_q, ret_miss_d, align_fault_q, align_fault_d;
    assign pc_plus = pc_q + WIDTH'(INC);
    assign ras_hit = ras_count != '0;
    assign bus.pc_result = pc_q;
    assign bus.pc_plus = pc_plus;
    assign bus.ras_count = ras_count;
    assign bus.ret_miss = ret_miss_q;
    assign bus.align_fault = align_fault_q;
    // priority select: redirect beats stall, call beats ret
    always_comb begin
        src = bus.redirect ? SRC_REDIRECT :
              bus.stall    ? SRC_HOLD :
              bus.call     ? SRC_CALL :
              bus.ret      ? SRC_RET : SRC_SEQ;
    end
    // next PC; only explicit targets are aligned and may raise a fault
    always_comb begin
        raw = src == SRC_REDIRECT ? bus.redirect_target :
              src == SRC_HOLD     ? pc_q :
              src == SRC_CALL     ? bus.call_target :
              (src == SRC_RET && ras_hit) ? ras_top : pc_plus;
        is_target = src == SRC_REDIRECT || src == SRC_CALL || (src == SRC_RET && ras_hit);
        ret_miss_d = src == SRC_RET && !ras_hit;
        align_fault_d = is_target && |(raw & LO_MASK);
        pc_d = is_target ? raw & ~LO_MASK : raw;
    end
    // PC register and one-cycle fault pulses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_VECTOR;
            ret_miss_q <= 1'b0;
            align_fault_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            ret_miss_q <= ret_miss_d;
            align_fault_q <= align_fault_d;
        end
    end
    pc_ras #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .push_i(src == SRC_CALL),
        .pop_i(src == SRC_RET && ras_hit),
        .push_data_i(pc_plus),
        .top_o(ras_top),
        .count_o(ras_count)
    );
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and random checks of pc_unit against a queue-based model
module tb_pc_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_pc;
    logic m_miss, m_fault;
    logic [31:0] ras_m [$];

    pc_unit_if #(.WIDTH(32), .RAS_DEPTH(4)) bus ();

    pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h0), .INC(4), .RAS_DEPTH(4)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("pc", bus.pc_result, m_pc);
        chk("pc_plus", bus.pc_plus, m_pc + 32'd4);
        chk("ras_count", 32'(bus.ras_count), 32'(ras_m.size()));
        chk("ret_miss", 32'(bus.ret_miss), 32'(m_miss));
        chk("align_fault", 32'(bus.align_fault), 32'(m_fault));
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_miss = 1'b0;
        m_fault = 1'b0;
        ras_m.delete();
    endtask

    // drive one cycle's inputs, advance the model, then check just after the edge
    task automatic step(input logic s, input logic r, input logic [31:0] rt,
                        input logic c, input logic [31:0] ct, input logic rr);
        logic [31:0] plus, raw;
        logic tgt;
        bus.stall = s;
        bus.redirect = r;
        bus.redirect_target = rt;
        bus.call = c;
        bus.call_target = ct;
        bus.ret = rr;
        plus = m_pc + 32'd4;
        tgt = 1'b0;
        m_miss = 1'b0;
        if (r) begin
            raw = rt;
            tgt = 1'b1;
        end else if (s) begin
            raw = m_pc;
        end else if (c) begin
            if (ras_m.size() == 4) void'(ras_m.pop_front());
            ras_m.push_back(plus);
            raw = ct;
            tgt = 1'b1;
        end else if (rr) begin
            if (ras_m.size() > 0) begin
                raw = ras_m.pop_back();
                tgt = 1'b1;
            end else begin
                raw = plus;
                m_miss = 1'b1;
            end
        end else begin
            raw = plus;
        end
        m_fault = tgt && (raw % 4 != 0);
        m_pc = tgt ? raw - (raw % 4) : raw;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // reset raised between edges while a call is pending; must act before any edge
    task automatic mid_reset();
        bus.call = 1'b1;
        bus.call_target = 32'h0000_0abc;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_reset_pc", bus.pc_result, 32'h0);
        chk("mid_reset_cnt", 32'(bus.ras_count), 32'h0);
        chk("mid_reset_miss", 32'(bus.ret_miss), 32'h0);
        chk("mid_reset_fault", 32'(bus.align_fault), 32'h0);
        @(negedge clk);
        bus.call = 1'b0;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(3) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    initial begin
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_target = '0;
        bus.call = 1'b0;
        bus.call_target = '0;
        bus.ret = 1'b0;
        model_reset();
        #1;
        chk("reset_pc", bus.pc_result, 32'h0);
        chk("reset_cnt", 32'(bus.ras_count), 32'h0);
        chk("reset_miss", 32'(bus.ret_miss), 32'h0);
        chk("reset_fault", 32'(bus.align_fault), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        // sequential fetch from the reset vector
        idle(); chk("seq_4", bus.pc_result, 32'h4);
        idle(); chk("seq_8", bus.pc_result, 32'h8);
        idle(); chk("seq_c", bus.pc_result, 32'hC);
        idle(); chk("seq_10", bus.pc_result, 32'h10);
        // simple call/return
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        chk("call_pc", bus.pc_result, 32'h100);
        chk("call_cnt", 32'(bus.ras_count), 32'h1);
        idle(); chk("call_seq", bus.pc_result, 32'h104);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("ret_pc", bus.pc_result, 32'h14);
        chk("ret_cnt", 32'(bus.ras_count), 32'h0);
        // five nested calls overflow a 4-deep stack, then five returns
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000 * i, 1'b0);
        chk("sat_cnt", 32'(bus.ras_count), 32'h4);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); chk("lifo_1", bus.pc_result, 32'h4004);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); chk("lifo_2", bus.pc_result, 32'h3004);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); chk("lifo_3", bus.pc_result, 32'h2004);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); chk("lifo_4", bus.pc_result, 32'h1004);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("miss_pc", bus.pc_result, 32'h1008);
        chk("miss_pulse", 32'(bus.ret_miss), 32'h1);
        idle(); chk("miss_clear", 32'(bus.ret_miss), 32'h0);
        // call and ret together act as a call
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1);
        chk("callret_pc", bus.pc_result, 32'h300);
        chk("callret_cnt", 32'(bus.ras_count), 32'h1);
        // stall plus misaligned redirect
        step(1'b1, 1'b1, 32'h203, 1'b1, 32'h500, 1'b0);
        chk("redir_pc", bus.pc_result, 32'h200);
        chk("redir_fault", 32'(bus.align_fault), 32'h1);
        chk("redir_cnt", 32'(bus.ras_count), 32'h1);
        idle(); chk("fault_clear", 32'(bus.align_fault), 32'h0);
        // stall ignores call/ret
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h700, 1'b0);
        chk("stall_pc", bus.pc_result, 32'h204);
        // wrap at top of address space
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
        idle();
        chk("wrap_pc", bus.pc_result, 32'h0);
        chk("wrap_fault", 32'(bus.align_fault), 32'h0);
        mid_reset();
        idle(); chk("post_reset", bus.pc_result, 32'h4);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 2) mid_reset();
            else step($urandom_range(99) < 20, $urandom_range(99) < 10, rnd_tgt(),
                      $urandom_range(99) < 25, rnd_tgt(), $urandom_range(99) < 30);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32, meaning PC and address width in bits.
REQ-002 Parameter RESET_VECTOR, default 32'h00000000, meaning PC value loaded on reset.
REQ-003 Parameter INC, default 4, meaning sequential increment in bytes; the unit SHALL require INC to be a power of two.
REQ-004 Parameter RAS_DEPTH, default 4, meaning return-address-stack entries; the unit SHALL require RAS_DEPTH to be a power of two and at least 2.
REQ-005 Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 Stall  input  1  hold PC and RAS for this cycle.
REQ-008 Redirect  input  1  resolved branch/jump from execute; overrides prediction.
REQ-009 RedirectTarget  input  WIDTH  target address for Redirect.
REQ-010 Call  input  1  predicted call; push return address and jump.
REQ-011 CallTarget  input  WIDTH  target address for Call.
REQ-012 Ret  input  1  predicted return; pop RAS and jump.
REQ-013 PCResult  output  WIDTH  registered current PC.
REQ-014 PCPlus  output  WIDTH  combinational PCResult + INC, modulo 2^WIDTH.
REQ-015 RasCount  output  clog2(RAS_DEPTH)+1  registered number of valid RAS entries.
REQ-016 RetMiss  output  1  registered one-cycle pulse: Ret accepted with empty RAS.
REQ-017 AlignFault  output  1  registered one-cycle pulse: loaded target had nonzero low clog2(INC) bits.

Function
REQ-018 Next-PC priority SHALL be: Redirect > Stall > Call > Ret > sequential (PCPlus).
REQ-019 Redirect SHALL load RedirectTarget even when Stall is high; the RAS SHALL be unchanged.
REQ-020 Stall without Redirect SHALL hold PCResult and the RAS; Call and Ret SHALL be ignored.
REQ-021 An accepted Call SHALL push PCPlus onto the RAS and load CallTarget.
REQ-022 Call and Ret together SHALL be treated as Call only.
REQ-023 An accepted Ret with RasCount>0 SHALL load the top entry and decrement RasCount.
REQ-024 An accepted Ret with RasCount=0 SHALL load PCPlus and pulse RetMiss for one cycle.
REQ-025 A push with RasCount=RAS_DEPTH SHALL overwrite the oldest entry (circular top pointer) and keep RasCount saturated at RAS_DEPTH.
REQ-026 Any loaded target (Redirect, Call, popped entry) with nonzero low clog2(INC) bits SHALL load with those bits cleared and pulse AlignFault for one cycle.
REQ-027 PC arithmetic SHALL wrap modulo 2^WIDTH without flagging.
REQ-028 Latency: an accepted input SHALL appear on PCResult after exactly one rising edge.
REQ-029 RetMiss and AlignFault SHALL be low in every cycle without a triggering event.

Reset
REQ-030 Reset assertion SHALL immediately force PCResult=RESET_VECTOR, RasCount=0, top pointer=0, RetMiss=0, AlignFault=0, without waiting for Clk.
REQ-031 Reset asserted mid-operation SHALL discard any pending Call/Ret/Redirect in that cycle.
REQ-032 RAS entry storage need not be reset; entries beyond RasCount SHALL never be observable.
REQ-033 The first rising edge after Reset deasserts SHALL apply normal next-PC rules starting from RESET_VECTOR.

Structure
REQ-034 A shared package SHALL hold the default WIDTH, INC, RESET_VECTOR and the next-PC-source enumeration (REDIRECT, HOLD, CALL, RET, SEQ).
REQ-035 The RAS SHALL be a sub-module named pc_ras (push, pop, top, count, circular pointer); pc_unit owns priority, PC register and fault flags.

Verification
REQ-036 Reset pulse then 3 free cycles -> PCResult 0x0, 0x4, 0x8, 0xC.
REQ-037 At PC=0x10 Call to 0x100; at 0x104 Ret -> PCResult 0x100, 0x104, 0x14; RasCount 1 then 0.
REQ-038 Five nested Calls with RAS_DEPTH=4, then five Rets -> first four Rets return in LIFO order, RasCount saturates at 4, fifth Ret pulses RetMiss and loads PCPlus.
REQ-039 Stall and Redirect to 0x203 together -> PCResult=0x200 next cycle, AlignFault pulses once, RAS unchanged.
REQ-040 PC=0xFFFFFFFC sequential -> PCResult=0x00000000, no fault; Reset asserted between edges -> PCResult=RESET_VECTOR before next edge.
